// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display blocks: blanking constants,
// scan FSM states and the active-low hex-to-segment table.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    // Segment order {g,f,e,d,c,b,a}, 0 = segment lit.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex digit to active-low 7-segment pattern.
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    assign seg_o = hex_to_seg(hex_i);

endmodule

// File: rtl/seg7_scan_controller.sv
// Scans a 16-bit hex value across a 4-digit common-anode display, with a
// blanked lead-in per digit slot and frame-aligned updates from a pending buffer.
module seg7_scan_controller
    import seg7_pkg::*;
#(
    parameter int TICK_DIV     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        lz_suppress,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PCNT_LAST  = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_CYCLES - 1);

    state_t        state_q;
    logic [PW-1:0] pcnt_q;
    logic [1:0]    idx_q;
    logic [15:0]   act_val_q;
    logic [3:0]    act_dp_q;
    logic [15:0]   pend_val_q;
    logic [3:0]    pend_dp_q;
    logic          pend_full_q;
    logic [3:0]    an_q;
    logic [6:0]    seg_q;
    logic          dp_q;
    logic          frame_done_q;

    logic          tick;
    logic          boundary;
    logic          load_fire;
    logic [3:0]    digit_sel;
    logic [6:0]    dec_seg;
    logic [3:0]    nz;
    logic [3:0]    lz_blank;
    logic [3:0]    an_d;
    logic [6:0]    seg_d;
    logic          dp_d;

    assign tick      = (state_q != IDLE) && (pcnt_q == PCNT_LAST);
    assign boundary  = tick && (idx_q == 2'd3);
    assign load_fire = load_valid && !pend_full_q;

    // A digit is blanked only if it and every digit above it are zero; digit 0 always shows.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lz
        assign nz[gi] = |act_val_q[gi*4 +: 4];
        if (gi == 0) begin : g_d0
            assign lz_blank[gi] = 1'b0;
        end else begin : g_dk
            assign lz_blank[gi] = lz_suppress && !(|nz[3:gi]);
        end
    end

    assign digit_sel = act_val_q[{idx_q, 2'b00} +: 4];

    seg7_hex_decoder u_dec (
        .hex_i (digit_sel),
        .seg_o (dec_seg)
    );

    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (state_q == SHOW) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = lz_blank[idx_q] ? SEG_BLANK : dec_seg;
            dp_d  = ~act_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pcnt_q       <= '0;
            idx_q        <= '0;
            act_val_q    <= '0;
            act_dp_q     <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_full_q  <= 1'b0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= boundary;

            // Pending can only be full or accepting, never both, so these never collide.
            if (boundary && pend_full_q) begin
                act_val_q   <= pend_val_q;
                act_dp_q    <= pend_dp_q;
                pend_full_q <= 1'b0;
            end else if (load_fire) begin
                pend_val_q  <= value;
                pend_dp_q   <= dp_in;
                pend_full_q <= 1'b1;
            end

            if (!en) begin
                state_q <= IDLE;
                pcnt_q  <= '0;
                idx_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= BLANK;
                        pcnt_q  <= '0;
                        idx_q   <= '0;
                    end
                    BLANK: begin
                        pcnt_q <= pcnt_q + 1'b1;
                        if (pcnt_q == BLANK_LAST) begin
                            state_q <= SHOW;
                        end
                    end
                    SHOW: begin
                        if (tick) begin
                            pcnt_q  <= '0;
                            idx_q   <= idx_q + 2'd1;
                            state_q <= BLANK;
                        end else begin
                            pcnt_q <= pcnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        pcnt_q  <= '0;
                        idx_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;
    assign load_ready = !pend_full_q;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Self-checking bench for seg7_scan_controller: per-cycle reference model,
// a table of display vectors, and directed multi-cycle corner sequences.
module tb_seg7_scan_controller;

    localparam int TD = 8;
    localparam int BC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        lz_suppress;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    always #5 clk = ~clk;

    seg7_scan_controller #(.TICK_DIV(TD), .BLANK_CYCLES(BC)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .value       (value),
        .dp_in       (dp_in),
        .lz_suppress (lz_suppress),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .frame_done  (frame_done)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: scan position is derived from clocks elapsed since enable.
    bit          m_run;
    int          m_elapsed;
    logic [15:0] m_act_val, m_pend_val;
    logic [3:0]  m_act_dp, m_pend_dp;
    bit          m_pend_full;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_ready, e_fd;
    logic [6:0]  seg_tab [16];

    typedef struct {
        logic [15:0] val;
        logic [3:0]  dpi;
        logic        lz;
        logic [27:0] segs;  // {d3,d2,d1,d0}
        logic [3:0]  dpn;   // active-low dp per digit
    } vec_t;
    vec_t vecs [8];

    logic [27:0] obs_seg;
    logic [3:0]  obs_dpn;
    int          obs_lit [4];
    int          obs_bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int pos, dig;
        bit bnd;
        if (rst) begin
            m_run = 0; m_elapsed = 0; m_act_val = '0; m_act_dp = '0;
            m_pend_val = '0; m_pend_dp = '0; m_pend_full = 0;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_ready = 1'b1; e_fd = 1'b0;
            return;
        end
        pos = m_elapsed % TD;
        dig = (m_elapsed / TD) % 4;
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
        if (m_run && pos >= BC) begin
            e_an = ~(4'b0001 << dig);
            if (lz_suppress && dig > 0 && (m_act_val >> (4 * dig)) == 16'h0)
                e_seg = 7'h7F;
            else
                e_seg = seg_tab[(m_act_val >> (4 * dig)) & 16'hF];
            e_dp = ~m_act_dp[dig];
        end
        bnd = m_run && pos == TD - 1 && dig == 3;
        e_fd = bnd;
        if (bnd && m_pend_full) begin
            m_act_val = m_pend_val; m_act_dp = m_pend_dp; m_pend_full = 0;
        end else if (load_valid && !m_pend_full) begin
            m_pend_val = value; m_pend_dp = dp_in; m_pend_full = 1;
        end
        e_ready = !m_pend_full;
        if (!en) begin
            m_run = 0; m_elapsed = 0;
        end else if (!m_run) begin
            m_run = 1; m_elapsed = 0;
        end else begin
            m_elapsed++;
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk("cycle_outputs", {18'h0, an, seg, dp, load_ready, frame_done},
            {18'h0, e_an, e_seg, e_dp, e_ready, e_fd});
    endtask

    function automatic int an2dig(input logic [3:0] a);
        case (a)
            4'hE:    return 0;
            4'hD:    return 1;
            4'hB:    return 2;
            4'h7:    return 3;
            default: return -1;
        endcase
    endfunction

    task automatic load(input logic [15:0] v, input logic [3:0] d);
        int n;
        bit was_ready;
        n = 0;
        load_valid = 1'b1; value = v; dp_in = d;
        forever begin
            was_ready = load_ready;
            cycle();
            if (was_ready) break;
            n++;
            if (n > 200) begin
                chk("load_timeout", load_ready, 1);
                break;
            end
        end
        load_valid = 1'b0;
        $display("load value=%h dp=%b accepted after %0d wait cycles", v, d, n);
    endtask

    task automatic wait_fd();
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while (frame_done !== 1'b1 && n < 100);
        if (frame_done !== 1'b1) chk("frame_done_timeout", frame_done, 1);
    endtask

    task automatic observe_frame();
        int k;
        obs_seg = '1; obs_dpn = '1; obs_bad = 0;
        for (int i = 0; i < 4; i++) obs_lit[i] = 0;
        for (int c = 0; c < 4 * TD; c++) begin
            cycle();
            k = an2dig(an);
            if (k < 0) begin
                if (an !== 4'hF) obs_bad++;
            end else begin
                obs_seg[k*7 +: 7] = seg;
                obs_dpn[k] = dp;
                obs_lit[k]++;
            end
        end
    endtask

    initial begin
        int n;
        bit was_ready, was_fd;

        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        vecs[0] = '{16'h12AB, 4'b0100, 1'b0, {7'h79, 7'h24, 7'h08, 7'h03}, 4'b1011};
        vecs[1] = '{16'h0005, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h12}, 4'b1111};
        vecs[2] = '{16'h0000, 4'b0001, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1110};
        vecs[3] = '{16'h0105, 4'b0000, 1'b1, {7'h7F, 7'h79, 7'h40, 7'h12}, 4'b1111};
        vecs[4] = '{16'h0105, 4'b0000, 1'b0, {7'h40, 7'h79, 7'h40, 7'h12}, 4'b1111};
        vecs[5] = '{16'hCDEF, 4'b1001, 1'b0, {7'h46, 7'h21, 7'h06, 7'h0E}, 4'b0110};
        vecs[6] = '{16'h3478, 4'b0010, 1'b1, {7'h30, 7'h19, 7'h78, 7'h00}, 4'b1101};
        vecs[7] = '{16'h00A0, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h08, 7'h40}, 4'b1111};

        rst = 1'b1; en = 1'b0; load_valid = 1'b0; value = '0; dp_in = '0; lz_suppress = 1'b0;

        // Reset state
        repeat (3) cycle();
        chk("rst_an", an, 4'hF);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_dp", dp, 1);
        chk("rst_ready", load_ready, 1);
        chk("rst_fd", frame_done, 0);
        rst = 1'b0;
        cycle();

        // Enable with nothing loaded: digit 0 shows zero
        en = 1'b1;
        n = 0;
        do begin cycle(); n++; end while (an === 4'hF && n < 10);
        chk("first_lit_latency", n, 4);
        chk("first_lit_an", an, 4'hE);
        chk("first_lit_seg", seg, 7'h40);

        // Table of display vectors
        foreach (vecs[i]) begin
            lz_suppress = vecs[i].lz;
            load(vecs[i].val, vecs[i].dpi);
            wait_fd();
            observe_frame();
            chk($sformatf("vec%0d_segs", i), obs_seg, vecs[i].segs);
            chk($sformatf("vec%0d_dp", i), obs_dpn, vecs[i].dpn);
            chk($sformatf("vec%0d_stray_an", i), obs_bad, 0);
            for (int k = 0; k < 4; k++)
                chk($sformatf("vec%0d_lit%0d", i, k), obs_lit[k], TD - BC);
        end

        // Back-to-back loads: second is held until the clock after a boundary
        lz_suppress = 1'b0;
        load(16'h1111, 4'b0000);
        chk("b2b_ready_drop", load_ready, 0);
        load_valid = 1'b1; value = 16'h2222; dp_in = 4'b0000;
        n = 0;
        forever begin
            was_ready = load_ready;
            was_fd = frame_done;
            cycle();
            n++;
            if (was_ready) begin
                chk("b2b_accept_after_boundary", was_fd, 1);
                break;
            end
            if (n > 100) begin
                chk("b2b_accept_timeout", load_ready, 1);
                break;
            end
        end
        load_valid = 1'b0;
        $display("load value=2222 dp=0000 accepted after %0d wait cycles", n);
        n = 0;
        do begin
            cycle();
            n++;
            if (an !== 4'hF) chk("b2b_first_value", seg, 7'h79);
        end while (frame_done !== 1'b1 && n < 100);
        observe_frame();
        chk("b2b_second_value", obs_seg, {4{7'h24}});

        // Enable dropped during digit 2 SHOW with a load pending
        wait_fd();
        load(16'h4321, 4'b0000);
        n = 0;
        do begin cycle(); n++; end while (an !== 4'hB && n < 40);
        en = 1'b0;
        cycle();
        chk("en0_lag_an", an, 4'hB);
        cycle();
        chk("en0_dark_an", an, 4'hF);
        repeat (5) cycle();
        chk("en0_pending_kept", load_ready, 0);
        en = 1'b1;
        n = 0;
        do begin cycle(); n++; end while (an === 4'hF && n < 10);
        chk("reen_latency", n, 4);
        chk("reen_an", an, 4'hE);
        wait_fd();
        chk("reen_ready_back", load_ready, 1);
        observe_frame();
        chk("reen_applied", obs_seg, {7'h19, 7'h30, 7'h24, 7'h79});

        // Reset mid-frame with a pending value
        wait_fd();
        load(16'h9999, 4'b1111);
        repeat (3) cycle();
        rst = 1'b1;
        cycle();
        chk("rst_mid_an", an, 4'hF);
        chk("rst_mid_ready", load_ready, 1);
        rst = 1'b0;
        wait_fd();
        observe_frame();
        chk("rst_mid_zero", obs_seg, {4{7'h40}});
        chk("rst_mid_dp", obs_dpn, 4'hF);

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            en = ($urandom_range(0, 39) != 0);
            load_valid = ($urandom_range(0, 3) == 0);
            value = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 3)));
            dp_in = 4'($urandom);
            if ($urandom_range(0, 7) == 0) lz_suppress = ~lz_suppress;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
